// File: rtl/pc_stack_pkg.sv
// Shared types for the program-counter / return-stack unit.
package pc_stack_pkg;

  localparam int unsigned STATUS_W   = 4;
  // Widest fetch address an entry can carry; narrower units zero-extend.
  localparam int unsigned ADDR_MAX_W = 32;

  typedef logic [STATUS_W-1:0] status_t;

  // One command per instruction boundary, after priority resolution.
  typedef enum logic [2:0] {
    NONE,
    ADV,
    JMP,
    CALL,
    RET,
    RETI,
    IRQ
  } cmd_e;

  // Return-stack entry: saved status nibble above the return address.
  typedef struct packed {
    status_t                 status;
    logic [ADDR_MAX_W-1:0]   addr;
  } stack_entry_t;

  localparam int unsigned ENTRY_W = $bits(stack_entry_t);

  // reti > ret > call > jump > advance; an interrupt replaces jump/advance.
  function automatic cmd_e encodeCmd(
    input logic reti,
    input logic ret,
    input logic call,
    input logic jump,
    input logic advance,
    input logic irqTake
  );
    cmd_e c;
    if (reti)                 c = RETI;
    else if (ret)             c = RET;
    else if (call)            c = CALL;
    else if (jump || advance) c = irqTake ? IRQ : (jump ? JMP : ADV);
    else                      c = NONE;
    return c;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Registered LIFO with occupancy flags and overflow/underflow strobes.
// The pointer never wraps: a push while full and a pop while empty are
// dropped and reported on the strobes instead.
module return_stack #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] topData,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             doPush;
  logic             doPop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign doPop     = pop && !empty;
  assign doPush    = push && !pop && !full;
  assign overflow  = push && !pop && full;
  assign underflow = pop && empty;
  assign topData   = empty ? '0 : mem[PW'(count - CW'(1))];

  // Occupancy counter; pop takes precedence if both are requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (doPop) begin
      count <= count - CW'(1);
    end else if (doPush) begin
      count <= count + CW'(1);
    end
  end

  // Entry storage; contents beyond count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (doPush && !rst) begin
      mem[count[PW-1:0]] <= pushData;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program-counter unit: fetch address, hardware return stack, and
// prioritised interrupt entry/exit with status save/restore.
module pc_stack_unit
  import pc_stack_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned VEC_BASE   = 16'h0008,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance,
  input  logic                jump,
  input  logic [ADDR_W-1:0]   jump_target,
  input  logic                call,
  input  logic [ADDR_W-1:0]   call_target,
  input  logic                ret,
  input  logic                reti,
  input  logic                ei,
  input  logic                di,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [STATUS_W-1:0] status_in,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic                imem_re,
  output logic [NUM_IRQ-1:0]  irq_ack,
  output logic [STATUS_W-1:0] status_restore,
  output logic                status_restore_valid,
  output logic                ie,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                fault
);

  localparam int unsigned KW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pcInc;
  logic [ADDR_W-1:0]   pcNext;
  logic                reNext;
  logic                ieReg;
  logic                ieNext;
  logic [NUM_IRQ-1:0]  ackReg;
  logic [NUM_IRQ-1:0]  ackNext;
  logic [STATUS_W-1:0] srReg;
  logic [STATUS_W-1:0] srNext;
  logic                srvReg;
  logic                srvNext;
  logic                faultReg;
  logic                reReg;

  cmd_e                cmd;
  logic [KW-1:0]       irqIdx;
  logic [ADDR_W-1:0]   vecAddr;

  stack_entry_t        pushEnt;
  stack_entry_t        topEnt;
  logic                stkPush;
  logic                stkPop;
  logic                stkFull;
  logic                stkEmpty;
  logic                stkOvf;
  logic                stkUnf;

  assign pcInc = pc + ADDR_W'(1);

  // Lowest-index pending request wins (descending scan, last hit kept).
  always_comb begin
    irqIdx = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (irq[i-1]) irqIdx = KW'(i - 1);
    end
  end

  assign vecAddr = ADDR_W'(VEC_BASE + 32'(irqIdx) * VEC_STRIDE);

  // Resolve the single command executed this boundary.
  always_comb begin
    cmd = encodeCmd(reti, ret, call, jump, advance, ieReg && (|irq));
  end

  // Stack traffic: calls and interrupt entries push, returns pop.
  always_comb begin
    stkPush        = (cmd == CALL) || (cmd == IRQ);
    stkPop         = (cmd == RET) || (cmd == RETI);
    pushEnt.status = (cmd == IRQ) ? status_in : '0;
    pushEnt.addr   = ADDR_MAX_W'(((cmd == IRQ) && jump) ? jump_target : pcInc);
  end

  return_stack #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) uStack (
    .clk       (clk),
    .rst       (rst),
    .push      (stkPush),
    .pop       (stkPop),
    .pushData  (pushEnt),
    .topData   (topEnt),
    .full      (stkFull),
    .empty     (stkEmpty),
    .overflow  (stkOvf),
    .underflow (stkUnf)
  );

  // Next pc, fetch strobe, acknowledge and status-restore for this command.
  always_comb begin
    pcNext  = pc;
    reNext  = 1'b1;
    ackNext = '0;
    srNext  = srReg;
    srvNext = 1'b0;
    unique case (cmd)
      NONE: reNext = 1'b0;
      ADV:  pcNext = pcInc;
      JMP:  pcNext = jump_target;
      CALL: pcNext = call_target;
      RET:  pcNext = stkEmpty ? pcInc : ADDR_W'(topEnt.addr);
      RETI: begin
        if (stkEmpty) begin
          pcNext = pcInc;
        end else begin
          pcNext  = ADDR_W'(topEnt.addr);
          srNext  = topEnt.status;
          srvNext = 1'b1;
        end
      end
      IRQ: begin
        pcNext  = vecAddr;
        ackNext = NUM_IRQ'(1) << irqIdx;
      end
      default: reNext = 1'b0;
    endcase
  end

  // Interrupt enable: entry and a successful reti override ei/di; di beats ei.
  always_comb begin
    ieNext = ieReg;
    if (cmd == IRQ)       ieNext = 1'b0;
    else if (cmd == RETI) ieNext = stkEmpty ? ieReg : 1'b1;
    else if (di)          ieNext = 1'b0;
    else if (ei)          ieNext = 1'b1;
  end

  // Architectural registers, all updated on the command edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= ADDR_W'(RESET_ADDR);
      reReg    <= 1'b0;
      ieReg    <= 1'b0;
      ackReg   <= '0;
      srReg    <= '0;
      srvReg   <= 1'b0;
      faultReg <= 1'b0;
    end else begin
      pc       <= pcNext;
      reReg    <= reNext;
      ieReg    <= ieNext;
      ackReg   <= ackNext;
      srReg    <= srNext;
      srvReg   <= srvNext;
      faultReg <= faultReg || stkOvf || stkUnf;
    end
  end

  assign imem_addr            = pc;
  assign imem_re              = reReg;
  assign irq_ack              = ackReg;
  assign status_restore       = srReg;
  assign status_restore_valid = srvReg;
  assign ie                   = ieReg;
  assign stack_full           = stkFull;
  assign stack_empty          = stkEmpty;
  assign fault                = faultReg;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios with literal
// expectations plus randomized commands against a queue-based model.
module tb_pc_stack_unit;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, advance, jump, call, ret, reti, ei, di;
  logic [15:0] jump_target, call_target;
  logic [3:0]  irq, status_in;
  logic [15:0] imem_addr;
  logic        imem_re, status_restore_valid, ie, stack_full, stack_empty, fault;
  logic [3:0]  irq_ack, status_restore;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_stack_unit #(
    .ADDR_W(16), .DEPTH(DEPTH), .NUM_IRQ(4),
    .RESET_ADDR(0), .VEC_BASE(16'h0008), .VEC_STRIDE(4)
  ) dut (
    .clk(clk), .rst(rst), .advance(advance), .jump(jump),
    .jump_target(jump_target), .call(call), .call_target(call_target),
    .ret(ret), .reti(reti), .ei(ei), .di(di), .irq(irq),
    .status_in(status_in), .imem_addr(imem_addr), .imem_re(imem_re),
    .irq_ack(irq_ack), .status_restore(status_restore),
    .status_restore_valid(status_restore_valid), .ie(ie),
    .stack_full(stack_full), .stack_empty(stack_empty), .fault(fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [3:0] st; int unsigned a; } ent_t;
  ent_t        stk[$];
  int unsigned mPc;
  bit          mValid = 0;
  bit          mIe, mFault, mRe, mSrv;
  logic [3:0]  mAck, mSr;

  task automatic applyEiDi();
    if (di)      mIe = 0;
    else if (ei) mIe = 1;
  endtask

  task automatic doPush(input logic [3:0] st, input int unsigned a);
    ent_t e;
    if (stk.size() == DEPTH) mFault = 1;
    else begin
      e.st = st; e.a = a;
      stk.push_back(e);
    end
  endtask

  task automatic modelStep();
    int unsigned nxt;
    ent_t e;
    int k;
    if (rst) begin
      mValid = 1; mPc = 0; stk.delete();
      mIe = 0; mFault = 0; mRe = 0; mAck = 0; mSr = 0; mSrv = 0;
      return;
    end
    nxt = (mPc + 1) % 65536;
    mAck = 0; mSrv = 0; mRe = 1;
    if (reti) begin
      if (stk.size() == 0) begin mFault = 1; mPc = nxt; end
      else begin
        e = stk.pop_back();
        mPc = e.a; mSr = e.st; mSrv = 1; mIe = 1;
      end
    end else if (ret) begin
      if (stk.size() == 0) begin mFault = 1; mPc = nxt; end
      else begin e = stk.pop_back(); mPc = e.a; end
      applyEiDi();
    end else if (call) begin
      doPush(4'b0, nxt);
      mPc = call_target;
      applyEiDi();
    end else if (jump || advance) begin
      if (mIe && irq != 0) begin
        k = 0;
        while (!irq[k]) k++;
        doPush(status_in, jump ? int'(jump_target) : nxt);
        mPc = (8 + 4 * k) % 65536;
        mIe = 0;
        mAck = 4'(1 << k);
      end else begin
        mPc = jump ? int'(jump_target) : nxt;
        applyEiDi();
      end
    end else begin
      mRe = 0;
      applyEiDi();
    end
  endtask

  // Single compare process: advance the model on each edge, then check.
  always @(posedge clk) begin
    modelStep();
    #1;
    if (mValid) begin
      chk("imem_addr", imem_addr, mPc);
      chk("imem_re", imem_re, mRe);
      chk("irq_ack", irq_ack, mAck);
      chk("status_restore", status_restore, mSr);
      chk("status_restore_valid", status_restore_valid, mSrv);
      chk("ie", ie, mIe);
      chk("stack_full", stack_full, stk.size() == DEPTH);
      chk("stack_empty", stack_empty, stk.size() == 0);
      chk("fault", fault, mFault);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    rst = 0; advance = 0; jump = 0; call = 0; ret = 0; reti = 0;
    ei = 0; di = 0; irq = 0; status_in = 0; jump_target = 0; call_target = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clr();
    rst = 1;
    step();
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_empty", stack_empty, 1'b1);
    chk("rst_re", imem_re, 1'b0);
    rst = 0;

    // sequential fetch and wrap
    advance = 1;
    step(); chk("adv1", imem_addr, 16'h0001); chk("adv1_re", imem_re, 1'b1);
    step(); chk("adv2", imem_addr, 16'h0002);
    step(); chk("adv3", imem_addr, 16'h0003);
    clr(); jump = 1; jump_target = 16'hFFFF; step();
    clr(); advance = 1; step(); chk("wrap", imem_addr, 16'h0000);

    // call / ret
    clr(); jump = 1; jump_target = 16'h0010; step();
    clr(); call = 1; call_target = 16'h0200; step();
    chk("call_addr", imem_addr, 16'h0200); chk("call_empty", stack_empty, 1'b0);
    clr(); ret = 1; step();
    chk("ret_addr", imem_addr, 16'h0011); chk("ret_empty", stack_empty, 1'b1);

    // interrupt entry and reti
    clr(); ei = 1; step(); chk("ei", ie, 1'b1);
    clr(); jump = 1; jump_target = 16'h0040; step();
    clr(); advance = 1; irq = 4'b0110; status_in = 4'b1010; step();
    chk("vec", imem_addr, 16'h000C); chk("ack", irq_ack, 4'b0010); chk("irq_ie", ie, 1'b0);
    clr(); advance = 1; step();
    clr(); reti = 1; step();
    chk("reti_addr", imem_addr, 16'h0041); chk("reti_sr", status_restore, 4'b1010);
    chk("reti_valid", status_restore_valid, 1'b1); chk("reti_ie", ie, 1'b1);
    clr(); step(); chk("valid_pulse", status_restore_valid, 1'b0);

    // interrupt deferred by call, taken on following advance
    clr(); jump = 1; jump_target = 16'h0100; step();
    clr(); call = 1; call_target = 16'h0300; irq = 4'b0001; step();
    chk("defer_addr", imem_addr, 16'h0300); chk("defer_ack", irq_ack, 4'b0000);
    clr(); advance = 1; irq = 4'b0001; status_in = 4'b0011; step();
    chk("late_vec", imem_addr, 16'h0008); chk("late_ack", irq_ack, 4'b0001);
    clr(); reti = 1; step(); chk("late_reti", imem_addr, 16'h0301);
    clr(); ret = 1; step(); chk("late_ret", imem_addr, 16'h0101);

    // overflow and underflow
    clr(); rst = 1; step();
    clr(); call = 1; call_target = 16'h0500;
    for (int i = 0; i < DEPTH; i++) step();
    chk("full", stack_full, 1'b1); chk("full_nofault", fault, 1'b0);
    step();
    chk("ovf_fault", fault, 1'b1); chk("ovf_addr", imem_addr, 16'h0500);
    clr(); rst = 1; step();
    clr(); ret = 1; step();
    chk("unf_addr", imem_addr, 16'h0001); chk("unf_fault", fault, 1'b1);

    // simultaneous commands, ei/di, reset priority
    clr(); rst = 1; step();
    clr(); call = 1; jump = 1; call_target = 16'h0600; jump_target = 16'h0700; step();
    chk("call_wins", imem_addr, 16'h0600);
    clr(); ei = 1; step();
    clr(); ei = 1; di = 1; step(); chk("di_wins", ie, 1'b0);
    clr(); call = 1; call_target = 16'h0800; rst = 1; step();
    chk("rst_call_addr", imem_addr, 16'h0000); chk("rst_call_empty", stack_empty, 1'b1);

    // randomized commands
    for (int n = 0; n < 4000; n++) begin
      clr();
      rst         = ($urandom_range(0, 299) == 0);
      reti        = ($urandom_range(0, 99) < 7);
      ret         = ($urandom_range(0, 99) < 7);
      call        = ($urandom_range(0, 99) < 14);
      jump        = ($urandom_range(0, 99) < 20);
      advance     = ($urandom_range(0, 99) < 55);
      ei          = ($urandom_range(0, 99) < 12);
      di          = ($urandom_range(0, 99) < 5);
      irq         = ($urandom_range(0, 99) < 30) ? 4'($urandom) : 4'b0;
      status_in   = 4'($urandom);
      jump_target = 16'($urandom);
      call_target = 16'($urandom);
      step();
    end

    clr();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
